byte_mem4: RTL and testbench
============================

BYTE_MEM4 -- requirements
Module: byte_mem4

Interface
REQ-001 Parameter INIT_VAL, default 8'h00: value loaded into every byte on reset and on clr.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 wr_valid  input  1  write request.
REQ-005 wr_ready  output  1  write can be accepted this cycle.
REQ-006 wr_auto  input  1  1 = use the internal write pointer; 0 = use wr_addr.
REQ-007 wr_addr  input  2  explicit byte address.
REQ-008 wr_data  input  8  write data.
REQ-009 clr  input  1  synchronous clear of contents and flags.
REQ-010 start  input  1  one-cycle pulse that requests a scan.
REQ-011 mem0, mem1, mem2, mem3  output  8 each  registered byte contents.
REQ-012 sel  output  2  scan index for the downstream byte selector.
REQ-013 sel_valid  output  1  sel is meaningful this cycle.
REQ-014 scan_done  output  1  one-cycle pulse after the last scan index.
REQ-015 full  output  1  all four bytes written since the last clr or reset.
REQ-016 wr_ptr  output  2  current auto-write pointer.

Function
REQ-017 A write SHALL be accepted when wr_valid and wr_ready are both 1 at a rising edge; the target byte SHALL update on that edge and be visible on memN the next cycle.
REQ-018 The target address SHALL be wr_ptr when wr_auto=1, and wr_addr otherwise.
REQ-019 wr_ptr SHALL increment by 1 on every accepted auto write and wrap from 3 to 0; explicit writes SHALL NOT change wr_ptr.
REQ-020 Each byte SHALL have a written flag, set on an accepted write to that byte; full SHALL equal the AND of all four flags.
REQ-021 The FSM SHALL have three states: IDLE, SCAN and DONE.
- IDLE to SCAN on start=1.
- SCAN holds for exactly 4 cycles, with sel = 0, 1, 2, 3.
- SCAN to DONE after sel=3.
- DONE to IDLE after 1 cycle.
REQ-022 sel_valid SHALL be 1 only in SCAN; scan_done SHALL be 1 only in DONE.
REQ-023 sel SHALL be 0 outside SCAN.
REQ-024 wr_ready SHALL be 1 in IDLE and DONE, and 0 in SCAN, so bytes stay stable while scanned.
REQ-025 start SHALL be ignored in SCAN and DONE; no queuing.
REQ-026 When start and an accepted write coincide in IDLE, the write SHALL complete and the scan SHALL begin next cycle, using the new data.
REQ-027 clr SHALL take effect on any state and takes priority over a simultaneous write:
- all memN = INIT_VAL;
- written flags = 0;
- wr_ptr = 0;
- FSM returns to IDLE, aborting any scan with no scan_done pulse.
REQ-028 When clr and start coincide, clr SHALL win and no scan SHALL start.
REQ-029 Two accepted writes to the same byte on consecutive cycles SHALL leave the later data.

Reset
REQ-030 When rst_n=0 at a rising edge, the block SHALL set:
- memN = INIT_VAL;
- written flags = 0, so full = 0;
- wr_ptr = 0;
- FSM = IDLE, so sel = 0, sel_valid = 0, scan_done = 0 and wr_ready = 1 from the next cycle.
REQ-031 Reset asserted mid-scan SHALL abort the scan with no scan_done pulse.
REQ-032 Reset SHALL take priority over clr, start and writes.

Structure
REQ-033 A shared package byte_mem_pkg SHALL hold:
- the FSM state typedef (IDLE, SCAN, DONE);
- NUM_BYTES = 4;
- SCAN_LEN = 4.
REQ-034 The FSM and the sel/scan_done generation SHALL live in one sub-module, byte_scan_fsm; the storage, written flags and write pointer SHALL stay in byte_mem4.

Verification
REQ-035 Reset then idle: memN = 00, full = 0, wr_ready = 1, sel_valid = 0.
REQ-036 Auto-write A1, B2, C3, D4 on consecutive cycles: mem0..mem3 = A1, B2, C3, D4; full = 1; wr_ptr = 0.
REQ-037 start with contents 11, 22, 33, 44:
- sel = 0, 1, 2, 3 with sel_valid = 1 for 4 cycles;
- scan_done = 1 for 1 cycle;
- wr_ready = 0 throughout SCAN;
- a write held during SCAN is accepted in DONE.
REQ-038 Explicit write 5A to address 2 together with start in IDLE: mem2 = 5A by the time sel = 2.
REQ-039 clr asserted at the second SCAN cycle, together with a write of FF:
- all memN = 00;
- FSM in IDLE, with no scan_done pulse;
- the write is discarded.
REQ-040 rst_n=0 mid-scan after a partial auto fill: all outputs return to reset values in the next cycle; a following auto write lands in mem0.

Source files
------------

// File: rtl/byte_mem_pkg.sv
// Shared types and sizing for the 4-byte scanned memory.
package byte_mem_pkg;

    localparam int NUM_BYTES = 4;
    localparam int SCAN_LEN  = 4;
    localparam int AW        = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // One resolved write: target byte already chosen between pointer and address.
    typedef struct packed {
        logic          fire;
        logic          bump;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_req_t;

endpackage

// File: rtl/byte_scan_fsm.sv
// Scan sequencer: walks sel over every byte once per start, then pulses scan_done.
// All outputs are registered and move together with the state.
module byte_scan_fsm
    import byte_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          start,
    output logic [AW-1:0] sel,
    output logic          sel_valid,
    output logic          scan_done,
    output logic          wr_ready
);

    localparam logic [AW-1:0] SEL_LAST = AW'(SCAN_LEN - 1);

    scan_state_t state;

    // State and registered outputs; clr aborts a scan silently, same as reset.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            scan_done <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        sel       <= '0;
                        sel_valid <= 1'b1;
                        wr_ready  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (sel == SEL_LAST) begin
                        state     <= DONE;
                        sel       <= '0;
                        sel_valid <= 1'b0;
                        scan_done <= 1'b1;
                        wr_ready  <= 1'b1;
                    end else begin
                        sel <= sel + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    scan_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    sel       <= '0;
                    sel_valid <= 1'b0;
                    scan_done <= 1'b0;
                    wr_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/byte_mem4.sv
// Four registered bytes with auto/explicit writes, written flags and a scan sequencer.
// Writes are blocked while scanning so the downstream selector sees stable data.
module byte_mem4
    import byte_mem_pkg::*;
#(
    parameter logic [7:0] INIT_VAL = 8'h00
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          wr_auto,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    input  logic          start,
    output logic [7:0]    mem0,
    output logic [7:0]    mem1,
    output logic [7:0]    mem2,
    output logic [7:0]    mem3,
    output logic [AW-1:0] sel,
    output logic          sel_valid,
    output logic          scan_done,
    output logic          full,
    output logic [AW-1:0] wr_ptr
);

    logic [NUM_BYTES-1:0][7:0] mem_q;
    logic [NUM_BYTES-1:0]      written_q;
    wr_req_t                   req;

    byte_scan_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .sel       (sel),
        .sel_valid (sel_valid),
        .scan_done (scan_done),
        .wr_ready  (wr_ready)
    );

    assign req = '{
        fire: wr_valid & wr_ready,
        bump: wr_auto,
        addr: wr_auto ? wr_ptr : wr_addr,
        data: wr_data
    };

    // Storage, written flags and auto pointer; clr outranks a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            mem_q     <= {NUM_BYTES{INIT_VAL}};
            written_q <= '0;
            wr_ptr    <= '0;
        end else if (req.fire) begin
            mem_q[req.addr]     <= req.data;
            written_q[req.addr] <= 1'b1;
            if (req.bump)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign full = &written_q;
    assign mem0 = mem_q[0];
    assign mem1 = mem_q[1];
    assign mem2 = mem_q[2];
    assign mem3 = mem_q[3];

endmodule

// File: tb/tb_byte_mem4.sv
// Directed bench: stimulus pushes expected scan events into a queue,
// a negedge monitor pops and compares every sel_valid / scan_done cycle.
module tb_byte_mem4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, wr_auto, clr, start;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready, sel_valid, scan_done, full;
    logic [7:0] mem0, mem1, mem2, mem3;
    logic [1:0] sel, wr_ptr;

    typedef struct {
        bit         is_done;
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    byte_mem4 #(.INIT_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_auto   (wr_auto),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr       (clr),
        .start     (start),
        .mem0      (mem0),
        .mem1      (mem1),
        .mem2      (mem2),
        .mem3      (mem3),
        .sel       (sel),
        .sel_valid (sel_valid),
        .scan_done (scan_done),
        .full      (full),
        .wr_ptr    (wr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [1:0] s);
        case (s)
            2'd0: pick = mem0;
            2'd1: pick = mem1;
            2'd2: pick = mem2;
            default: pick = mem3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic wr(input bit a, input logic [1:0] ad, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_auto  = a;
        wr_addr  = ad;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic push_sel(input logic [1:0] s, input logic [7:0] d);
        exp_t e;
        e.is_done = 1'b0;
        e.sel     = s;
        e.data    = d;
        q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.sel     = 2'd0;
        e.data    = 8'h00;
        q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem0"}, mem0, 8'h00);
        chk({tag, "_mem1"}, mem1, 8'h00);
        chk({tag, "_mem2"}, mem2, 8'h00);
        chk({tag, "_mem3"}, mem3, 8'h00);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_wr_ptr"}, wr_ptr, 2'd0);
        chk({tag, "_wr_ready"}, wr_ready, 1'b1);
        chk({tag, "_sel_valid"}, sel_valid, 1'b0);
        chk({tag, "_scan_done"}, scan_done, 1'b0);
        chk({tag, "_sel"}, sel, 2'd0);
    endtask

    // Monitor: every scan output cycle must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sel_valid === 1'b1) begin
                chk("scan_wr_ready", wr_ready, 1'b0);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sel actual sel=%0d required no scan", sel);
                end else begin
                    e = q.pop_front();
                    chk("ev_kind_sel", e.is_done, 1'b0);
                    chk("sel_index", sel, e.sel);
                    chk("sel_byte", pick(sel), e.data);
                end
            end else begin
                chk("sel_idle_zero", sel, 2'd0);
            end
            if (scan_done === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual scan_done=1 required 0");
                end else begin
                    e = q.pop_front();
                    chk("ev_kind_done", e.is_done, 1'b1);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_auto = 1'b0; wr_addr = 2'd0;
        wr_data = 8'h00; clr = 1'b0; start = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        settle();
        chk_reset_vals("rst");

        // Auto fill A1..D4 back to back; pointer wraps to 0
        wr(1'b1, 2'd0, 8'hA1); wr(1'b1, 2'd0, 8'hB2);
        wr(1'b1, 2'd0, 8'hC3); wr(1'b1, 2'd0, 8'hD4);
        settle();
        chk("fill_mem0", mem0, 8'hA1);
        chk("fill_mem1", mem1, 8'hB2);
        chk("fill_mem2", mem2, 8'hC3);
        chk("fill_mem3", mem3, 8'hD4);
        chk("fill_full", full, 1'b1);
        chk("fill_wr_ptr", wr_ptr, 2'd0);

        // Scan 11..44 with a write held through SCAN, landing in DONE
        wr(1'b1, 2'd0, 8'h11); wr(1'b1, 2'd0, 8'h22);
        wr(1'b1, 2'd0, 8'h33); wr(1'b1, 2'd0, 8'h44);
        push_sel(2'd0, 8'h11); push_sel(2'd1, 8'h22);
        push_sel(2'd2, 8'h33); push_sel(2'd3, 8'h44); push_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 2'd0; wr_data = 8'h99;
        tick(); tick(); tick(); tick();
        settle();
        chk("held_wr_blocked", mem0, 8'h11);
        chk("done_wr_ready", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        settle();
        chk("held_wr_landed", mem0, 8'h99);
        chk("explicit_keeps_ptr", wr_ptr, 2'd0);

        // Explicit write with start in IDLE: scan sees new data
        push_sel(2'd0, 8'h99); push_sel(2'd1, 8'h22);
        push_sel(2'd2, 8'h5A); push_sel(2'd3, 8'h44); push_done();
        start = 1'b1;
        wr(1'b0, 2'd2, 8'h5A);
        start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        settle();
        chk("wr_start_mem2", mem2, 8'h5A);

        // clr in the second SCAN cycle along with a write of FF
        push_sel(2'd0, 8'h99); push_sel(2'd1, 8'h22);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b1;
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 2'd3; wr_data = 8'hFF;
        tick();
        clr = 1'b0;
        wr_valid = 1'b0;
        settle();
        chk_reset_vals("clr_scan");
        tick(); tick(); tick();

        // clr beats an IDLE write; clr beats start
        wr(1'b1, 2'd0, 8'h12);
        clr = 1'b1;
        wr(1'b0, 2'd1, 8'hFF);
        clr = 1'b0;
        settle();
        chk("clr_wr_mem1", mem1, 8'h00);
        chk("clr_wr_mem0", mem0, 8'h00);
        chk("clr_wr_ptr", wr_ptr, 2'd0);
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        settle();
        chk("clr_start_no_scan", sel_valid, 1'b0);
        tick(); tick();

        // Same byte written twice in a row keeps the later data
        wr(1'b0, 2'd3, 8'hAA);
        wr(1'b0, 2'd3, 8'hBB);
        settle();
        chk("same_byte_last", mem3, 8'hBB);
        chk("same_byte_ptr", wr_ptr, 2'd0);

        // Reset mid-scan after a partial auto fill
        wr(1'b1, 2'd0, 8'h01); wr(1'b1, 2'd0, 8'h02);
        settle();
        chk("partial_ptr", wr_ptr, 2'd2);
        push_sel(2'd0, 8'h01); push_sel(2'd1, 8'h02);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        settle();
        chk_reset_vals("rst_scan");
        rst_n = 1'b1;
        wr(1'b1, 2'd0, 8'h77);
        settle();
        chk("post_rst_mem0", mem0, 8'h77);
        chk("post_rst_ptr", wr_ptr, 2'd1);
        tick(); tick(); tick();
        settle();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
